// File: rtl/debounced_pio_in.sv
// debounced_pio_in: debounced input PIO with edge capture and a maskable, level-sensitive IRQ.
//
// Ports:
//   clk_clk        system clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   in_export      raw asynchronous board inputs (WIDTH bits)
//   avs_address    Avalon-MM word address: 0 DATA, 1 IRQ_MASK, 2 EDGE_CAPTURE, 3 CTRL
//   avs_read       read strobe (read data returned one cycle later)
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, 0 outside the read-return cycle
//   irq            registered interrupt request, |(EDGE_CAPTURE & IRQ_MASK)
module debounced_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] in_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] InvMask = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrMask = 2'd1;
    localparam logic [1:0] AddrCap  = 2'd2;
    localparam logic [1:0] AddrCtrl = 2'd3;

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             irq_q;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] rise, fall, edge_sel, w1c;
    logic [31:0]      rd_mux;

    // Upper write-data bits have no destination when WIDTH < 32.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    // Per-bit debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Edge selection works on a one-cycle pulse, so a CTRL change cannot
    // resurrect an edge that already passed.
    always_comb begin
        rise = stable_q & ~stable_dly_q;
        fall = ~stable_q & stable_dly_q;
        if (ctrl_q[1]) begin
            edge_sel = rise | fall;
        end else if (ctrl_q[0]) begin
            edge_sel = fall;
        end else begin
            edge_sel = rise;
        end
    end

    always_comb begin
        w1c    = '0;
        mask_d = mask_q;
        ctrl_d = ctrl_q;
        if (avs_write) begin
            case (avs_address)
                AddrMask: mask_d = avs_writedata[WIDTH-1:0];
                AddrCap:  w1c    = avs_writedata[WIDTH-1:0];
                AddrCtrl: ctrl_d = avs_writedata[1:0];
                default:  ;
            endcase
        end
        // New edges are ORed in after the clear so a coincident set wins.
        cap_d = (cap_q & ~w1c) | edge_sel;
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            AddrData: rd_mux = 32'(stable_q);
            AddrMask: rd_mux = 32'(mask_q);
            AddrCap:  rd_mux = 32'(cap_q);
            AddrCtrl: rd_mux = 32'(ctrl_q);
            default:  rd_mux = '0;
        endcase
        rdata_d = avs_read ? rd_mux : '0;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            mask_q       <= '0;
            cap_q        <= '0;
            ctrl_q       <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            s1_q         <= in_export ^ InvMask;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mask_q       <= mask_d;
            cap_q        <= cap_d;
            ctrl_q       <= ctrl_d;
            irq_q        <= |(cap_q & mask_q);
            rdata_q      <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: doc/debounced_pio_in.md
# debounced_pio_in

Parametrised, debounced input PIO with edge capture and maskable interrupt, the successor to the fixed-width button and switch PIOs in the Nios accelerometer system. It synchronises and debounces `WIDTH` raw board inputs (keys, slide switches or the G-sensor INT line) and normalises their polarity. It records selected edges per bit and presents level, mask, capture and control registers on an Avalon-MM slave, with a level-sensitive IRQ to the Nios II.

## Interface

**Parameters**
- `WIDTH`, default 4: number of input bits, 1 to 32.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a level change is accepted. Must be at least 1. The default gives 1 ms at 50 MHz.
- `ACTIVE_LOW`, default 1: when 1, raw inputs are inverted, so a pressed key reads as 1.

**Ports**
- `clk_clk` input 1: system clock. All logic is on the rising edge.
- `reset_reset_n` input 1: asynchronous, active-low reset.
- `in_export` input WIDTH: raw, asynchronous board inputs.
- `avs_address` input 2: word register address.
- `avs_read` input 1: read strobe.
- `avs_write` input 1: write strobe.
- `avs_writedata` input 32: write data.
- `avs_readdata` output 32: registered read data.
- `irq` output 1: registered, level-sensitive interrupt request.

## Operation

**Register map** (unused bits read 0; writes to read-only fields are ignored)
- 0 `DATA` (RO): debounced, polarity-corrected level, bits [WIDTH-1:0].
- 1 `IRQ_MASK` (RW): one enable per bit. Reset value 0.
- 2 `EDGE_CAPTURE` (RW1C): sticky edge flags. Writing 1 to a bit clears it. Reset value 0.
- 3 `CTRL` (RW): bits [1:0] select the captured edge. 00 = rising, 01 = falling, 1x = both. Reset value 00.

**Input path, per bit `i`**
- Polarity: `norm = in_export ^ {WIDTH{ACTIVE_LOW}}`.
- Synchroniser: `norm` passes through two flops, `s1` then `s2`. Both reset to 0, the inactive level.
- Debounce counter `cnt[i]` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and resets to 0. Each cycle:
  - If `s2[i] == stable[i]`, then `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`, then `stable[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else `cnt[i] <= cnt[i] + 1`.
- `stable` resets to 0.
- Edge detect compares `stable` against a delayed copy `stable_d`, which also resets to 0. A rise or fall that matches `CTRL` sets `EDGE_CAPTURE[i]` on the following edge.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Changing `CTRL` never creates captures retroactively.
- `irq <= |(EDGE_CAPTURE & IRQ_MASK)`, registered. `irq` resets to 0.

## Timing

- **Reads:** `avs_readdata` is valid on the cycle after the edge at which `avs_read` is sampled, so read latency is 1. Outside that cycle `avs_readdata` is 0. Its reset value is 0.
- **Writes:** take effect at the edge where `avs_write` is sampled. The new value is visible to a read issued on the next cycle.
- **Input latency:** the raw input changes before edge E0.
  - `s2` updates at E1.
  - `stable`, and therefore `DATA`, updates at E(1+D), where D = `DEBOUNCE_CYCLES`.
  - `EDGE_CAPTURE` sets at E(2+D).
  - `irq` asserts at E(3+D).
- **Glitch rejection:** a pulse on `s2` lasting fewer than D cycles resets the counter and produces no change in `stable`.
- **D = 1:** `stable` follows `s2` one cycle later.
- **Bit independence:** counters are per bit. Simultaneous changes on several bits are debounced independently.
- **Reset mid-operation:** asserting `reset_reset_n` low at any time immediately clears all flops, counters, registers, `irq` and `avs_readdata`. In-flight debounces are discarded. After release, an input that is held active is accepted D+1 cycles later and produces a rising edge.
- **IRQ deassertion:** a W1C that clears the last masked capture deasserts `irq` one edge after the capture bit clears. Clearing `IRQ_MASK` has the same one-edge delay.

## Test plan

Bench configuration: `WIDTH=4`, `DEBOUNCE_CYCLES=4`, `ACTIVE_LOW=1`.

1. **Reset values:** hold `in_export=4'hF` through reset, then read all four registers. Required: every register reads 0 and `irq=0`.
2. **Debounce and IRQ:** write `IRQ_MASK=4'h1` and `CTRL=0`, then drive `in_export[0]=0` before E0. Required: `DATA=1` from E5, `EDGE_CAPTURE=1` at E6, `irq=1` at E7.
3. **Glitch rejection:** pulse `in_export[1]=0` for 3 cycles. Required: `DATA`, `EDGE_CAPTURE` and `irq` stay 0.
4. **Both-edges capture and W1C:** set `CTRL=2` and press then release bit 2. Required: `EDGE_CAPTURE[2]` sets on both the press and the release. Writing `EDGE_CAPTURE=4'h4` clears the bit, and `irq` drops one cycle later when the bit is masked.
5. **Set beats clear:** issue a W1C on bit 0 in the same cycle a new edge on bit 0 is detected. Required: `EDGE_CAPTURE[0]` stays 1.
6. **Reset mid-debounce:** assert reset at count 2 of a debounce on bit 3 while `in_export[3]` is held at 0. Required: all state clears, and after release `DATA[3]=1` appears 5 cycles later.
